// File: rtl/ch_seq_pkg.sv
// Shared types and helpers for the channel segment sequencer.
// Thermometer helper is sized for the largest supported segment count.
package ch_seq_pkg;

    localparam int MAX_SEG         = 16;
    localparam int MIN_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic logic [MAX_SEG-1:0] thermo(input logic [4:0] n);
        logic [MAX_SEG-1:0] mask_v;
        mask_v = {MAX_SEG{1'b0}};
        for (int i = 0; i < MAX_SEG; i++) begin
            mask_v[i] = (5'(i) < n);
        end
        return mask_v;
    endfunction

endpackage

// File: rtl/ch_disc_qualifier.sv
// Discriminator synchroniser, polarity selection and registered rising-edge detect.
// edge_q is held low while clr is asserted so stale edges never leak into a new run.
module ch_disc_qualifier
    import ch_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic FCLK,
    input  logic RSTB,
    input  logic disc_raw,
    input  logic polarity,
    input  logic clr,
    output logic edge_q
);

    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic              edge_r;
    logic              disc_q_s;

    assign disc_q_s = sync_r[STAGES-1] ^ polarity;

    // Synchroniser chain, previous-level tracker and edge register.
    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], disc_raw};
            prev_r <= disc_q_s;
            if (clr) begin
                edge_r <= 1'b0;
            end else begin
                edge_r <= disc_q_s & ~prev_r;
            end
        end
    end

    assign edge_q = edge_r;

endmodule

// File: rtl/ch_segment_sequencer.sv
// Channel trigger sequencer: qualified discriminator edges stop segments after a delay.
// Optional macro CH_EVENT_TIMESTAMP_EN adds LAST_TS, the cycle count from arming to each fire.
module ch_segment_sequencer
    import ch_seq_pkg::*;
#(
    parameter int NUM_SEG     = 5,
    parameter int DELAY_W     = 5,
    parameter int CNT_W       = $clog2(NUM_SEG + 1),
    parameter int SYNC_STAGES = 2,
    parameter int TS_W        = 10
) (
    input  logic               FCLK,
    input  logic               RSTB,
    input  logic               INST_START,
    input  logic               INST_STOP,
    input  logic               INST_READOUT,
    input  logic               DISCRIMINATOR_OUTPUT,
    input  logic               DISCRIMINATOR_POLARITY,
    input  logic [DELAY_W-1:0] TRIG_DELAY,
    input  logic [CNT_W-1:0]   SEG_PER_EVENT,
    output logic [NUM_SEG-1:0] TRIGGER,
    output logic [CNT_W-1:0]   TRIGGER_CNT,
    output logic               STOP_REQUEST,
`ifdef CH_EVENT_TIMESTAMP_EN
    output logic [TS_W-1:0]    LAST_TS,
`endif
    output logic               BUSY
);

    seq_state_t         state_r, state_n;
    logic [DELAY_W-1:0] cnt_r, cnt_n;
    logic [CNT_W-1:0]   segs_r, segs_n;
    logic [NUM_SEG-1:0] trig_r, trig_n;
    logic [CNT_W-1:0]   tcnt_r, tcnt_n;
    logic               stop_r, stop_n;
    logic               busy_r;
    logic               edge_s;
    logic               fire_s;
    logic               arm_s;
    logic [CNT_W-1:0]   remain_s;
    logic [CNT_W-1:0]   k_s;
    logic [CNT_W-1:0]   segs_fire_s;
    logic [NUM_SEG-1:0] trig_fire_s;

    ch_disc_qualifier #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_qual (
        .FCLK     (FCLK),
        .RSTB     (RSTB),
        .disc_raw (DISCRIMINATOR_OUTPUT),
        .polarity (DISCRIMINATOR_POLARITY),
        .clr      (state_r == IDLE),
        .edge_q   (edge_s)
    );

    // Segments consumed by one event: requested count clamped to what is left, never zero.
    always_comb begin
        remain_s = CNT_W'(NUM_SEG) - segs_r;
        if (SEG_PER_EVENT > remain_s) begin
            k_s = remain_s;
        end else begin
            k_s = SEG_PER_EVENT;
        end
        if (k_s == {CNT_W{1'b0}}) begin
            k_s = CNT_W'(1);
        end else begin
            k_s = k_s;
        end
        segs_fire_s = segs_r + k_s;
        trig_fire_s = NUM_SEG'(thermo(5'(segs_fire_s)));
    end

    // Next-state logic: stop beats fire, fire beats start.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        trig_n  = trig_r;
        stop_n  = stop_r;
        fire_s  = 1'b0;
        arm_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (INST_START) begin
                    arm_s = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            ARMED: begin
                if (INST_STOP) begin
                    state_n = DONE;
                    trig_n  = {NUM_SEG{1'b1}};
                end else if (edge_s) begin
                    if (TRIG_DELAY == {DELAY_W{1'b0}}) begin
                        fire_s = 1'b1;
                    end else begin
                        state_n = DELAY;
                        cnt_n   = TRIG_DELAY - DELAY_W'(1);
                    end
                end else begin
                    state_n = ARMED;
                end
            end
            DELAY: begin
                if (INST_STOP) begin
                    state_n = DONE;
                    trig_n  = {NUM_SEG{1'b1}};
                    cnt_n   = {DELAY_W{1'b0}};
                end else if (cnt_r == {DELAY_W{1'b0}}) begin
                    fire_s = 1'b1;
                end else begin
                    cnt_n = cnt_r - DELAY_W'(1);
                end
            end
            DONE: begin
                if (INST_START) begin
                    arm_s = 1'b1;
                end else if (INST_READOUT) begin
                    state_n = IDLE;
                    trig_n  = {NUM_SEG{1'b0}};
                    stop_n  = 1'b0;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (arm_s) begin
            state_n = ARMED;
            cnt_n   = {DELAY_W{1'b0}};
            segs_n  = {CNT_W{1'b0}};
            trig_n  = {NUM_SEG{1'b0}};
            tcnt_n  = {CNT_W{1'b0}};
            stop_n  = 1'b0;
        end else if (fire_s) begin
            cnt_n   = {DELAY_W{1'b0}};
            segs_n  = segs_fire_s;
            trig_n  = trig_fire_s;
            tcnt_n  = tcnt_r + CNT_W'(1);
            if (segs_fire_s == CNT_W'(NUM_SEG)) begin
                state_n = DONE;
                stop_n  = 1'b1;
            end else begin
                state_n = ARMED;
            end
        end else begin
            segs_n = segs_r;
            tcnt_n = tcnt_r;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            state_r <= IDLE;
            cnt_r   <= {DELAY_W{1'b0}};
            segs_r  <= {CNT_W{1'b0}};
            trig_r  <= {NUM_SEG{1'b0}};
            tcnt_r  <= {CNT_W{1'b0}};
            stop_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            segs_r  <= segs_n;
            trig_r  <= trig_n;
            tcnt_r  <= tcnt_n;
            stop_r  <= stop_n;
            busy_r  <= (state_n == ARMED) || (state_n == DELAY);
        end
    end

    assign TRIGGER      = trig_r;
    assign TRIGGER_CNT  = tcnt_r;
    assign STOP_REQUEST = stop_r;
    assign BUSY         = busy_r;

`ifdef CH_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_r;
    logic [TS_W-1:0] last_ts_r;

    // Run timer since arming; the snapshot counts the firing edge itself.
    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            ts_r      <= {TS_W{1'b0}};
            last_ts_r <= {TS_W{1'b0}};
        end else begin
            if (arm_s) begin
                ts_r <= {TS_W{1'b0}};
            end else if ((state_r == ARMED) || (state_r == DELAY)) begin
                ts_r <= ts_r + TS_W'(1);
            end else begin
                ts_r <= ts_r;
            end
            if (fire_s) begin
                last_ts_r <= ts_r + TS_W'(1);
            end else begin
                last_ts_r <= last_ts_r;
            end
        end
    end

    assign LAST_TS = last_ts_r;
`endif

endmodule

// File: doc/ch_segment_sequencer.md
Name: ch_segment_sequencer

Overview:
- Parametrised next-generation channel trigger sequencer. Runs entirely on the gated fast sampling clock FCLK.
- Synchronises and qualifies the raw discriminator and applies a programmable trigger delay. Each event stops a programmable number of the channel's NUM_SEG sampling segments.
- Reports the event count and raises STOP_REQUEST when every segment is stopped.
- Generalises the fixed 5-segment, 1/2/4-mode channel controller to any segment count and any segments-per-event value, with registered trigger outputs.

Parameters:
- NUM_SEG, 5, number of sampling segments (2..16).
- DELAY_W, 5, width of TRIG_DELAY.
- CNT_W, $clog2(NUM_SEG+1), width of SEG_PER_EVENT and TRIGGER_CNT.
- SYNC_STAGES, 2, discriminator synchroniser depth (at least 2).
- TS_W, 10, timestamp width (optional feature only).

Ports:
- FCLK  in  1  fast sampling clock.
- RSTB  in  1  asynchronous active-low reset.
- INST_START  in  1  single-FCLK-cycle pulse, synchronous to FCLK; arms the sequencer.
- INST_STOP  in  1  single-cycle pulse, synchronous; external stop.
- INST_READOUT  in  1  single-cycle pulse, synchronous; releases segments after readout.
- DISCRIMINATOR_OUTPUT  in  1  raw asynchronous discriminator.
- DISCRIMINATOR_POLARITY  in  1  0 = rising edge active, 1 = falling edge active. Static while armed.
- TRIG_DELAY  in  DELAY_W  delay in FCLK cycles from qualified edge to fire. Static while armed.
- SEG_PER_EVENT  in  CNT_W  segments stopped per event. Static while armed.
- TRIGGER  out  NUM_SEG  registered thermometer mask; bit i high means segment i is stopped.
- TRIGGER_CNT  out  CNT_W  number of fired events.
- STOP_REQUEST  out  1  all segments stopped by triggers.
- BUSY  out  1  high in ARMED or DELAY.

Behaviour:
- Reset: all outputs 0, state IDLE, delay counter 0, synchroniser flops 0, segs_used 0. Reset is asynchronous and may occur mid-operation; all state clears immediately.
- Qualification:
  - disc_q = synchronised DISCRIMINATOR_OUTPUT XOR DISCRIMINATOR_POLARITY.
  - A qualified edge is disc_q=1 with previous disc_q=0. Edge registers clear in IDLE.
- Effective segments per event k = max(1, min(SEG_PER_EVENT, NUM_SEG - segs_used)).
- Fire action, on one clock edge:
  - segs_used += k; TRIGGER = thermometer(segs_used); TRIGGER_CNT += 1.
  - If segs_used reaches NUM_SEG: go to DONE and set STOP_REQUEST. Otherwise go to ARMED.
- States:
  - IDLE: INST_START -> ARMED, clearing TRIGGER, TRIGGER_CNT, segs_used and STOP_REQUEST. INST_STOP and INST_READOUT are ignored.
  - ARMED: on a qualified edge:
    - TRIG_DELAY==0: fire on this edge.
    - Otherwise go to DELAY with cnt = TRIG_DELAY-1.
  - DELAY: cnt==0 -> fire; otherwise decrement cnt. Qualified edges during DELAY are discarded (no retrigger or queuing).
  - DONE: outputs hold.
    - INST_READOUT -> IDLE: clears TRIGGER and STOP_REQUEST; TRIGGER_CNT holds until the next INST_START.
    - INST_START -> ARMED with the same clears as from IDLE.
- INST_STOP in ARMED or DELAY:
  - Goes to DONE and sets TRIGGER to all ones.
  - STOP_REQUEST stays 0, a pending delay is discarded, and TRIGGER_CNT is unchanged.
- Priority within one cycle: INST_STOP over fire over INST_START. INST_START in ARMED or DELAY is ignored.
- Latency:
  - Raw pin to qualified edge: SYNC_STAGES+1 cycles.
  - Qualified edge to TRIGGER/TRIGGER_CNT/STOP_REQUEST update: TRIG_DELAY+1 cycles.
- Arithmetic:
  - TRIGGER_CNT never exceeds NUM_SEG, because each fire consumes at least one segment; no wrap is possible.
  - segs_used never exceeds NUM_SEG.

Optional Feature:
- Macro CH_EVENT_TIMESTAMP_EN.
- Defined:
  - Adds output LAST_TS [TS_W-1:0], reset 0.
  - A free-running TS_W counter clears on INST_START and increments every cycle in ARMED or DELAY, wrapping at 2^TS_W.
  - LAST_TS captures the counter value at each fire.
- Undefined: no counter and no LAST_TS port.

Decomposition:
- Package ch_seq_pkg:
  - seq_state_t enum {IDLE, ARMED, DELAY, DONE}.
  - Function thermo(n) returning the NUM_SEG mask.
  - Constant for the minimum SYNC_STAGES.
- Sub-module ch_disc_qualifier: SYNC_STAGES synchroniser, polarity XOR and edge detect, with FCLK and RSTB. Outputs edge_q.

Test Plan:
- NUM_SEG=5, SEG_PER_EVENT=1, TRIG_DELAY=0, 5 rising pulses spaced 20 cycles -> TRIGGER 00001, 00011, …, 11111; TRIGGER_CNT 1..5; STOP_REQUEST=1 after the 5th fire; BUSY=0.
- SEG_PER_EVENT=2, TRIG_DELAY=7, pulse at synchronised cycle E -> TRIGGER=00011 at E+8. The third event stops only 1 segment (clamp): 11111, TRIGGER_CNT=3, STOP_REQUEST=1.
- POLARITY=1, SEG_PER_EVENT=0 -> rising edges ignored; a falling edge stops 1 segment (0 treated as 1).
- TRIG_DELAY=10, second edge 4 cycles after the first -> only one fire, TRIGGER_CNT=1.
- INST_STOP during DELAY with TRIGGER=00001 -> TRIGGER=11111, STOP_REQUEST=0, TRIGGER_CNT=1. INST_READOUT -> TRIGGER=0, TRIGGER_CNT holds 1. INST_START -> TRIGGER_CNT=0.
- RSTB low mid-DELAY -> all outputs 0 immediately. INST_START and INST_STOP together in IDLE -> arms (STOP ignored in IDLE). With CH_EVENT_TIMESTAMP_EN, LAST_TS equals the cycle count from INST_START to the fire.
